// File: rtl/asteroid_controller_pkg.sv
// Shared definitions for the asteroid controller slice: the signed screen
// coordinate type, the screen geometry and the asteroid lifecycle states.
// The controller has one optional feature, horizontal drift, enabled by the
// macro ASTEROID_DRIFT_EN.
package asteroid_controller_pkg;

    localparam int COORD_W = 11;

    typedef logic signed [COORD_W-1:0] coord_t;
    // One extra bit so that sums such as topLeft + size never wrap
    typedef logic signed [COORD_W:0]   coord_wide_t;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FALLING   = 2'd1,
        ST_EXPLODING = 2'd2
    } asteroid_state_t;

    // Sign-extend a coordinate into the wide arithmetic type
    function automatic coord_wide_t widen(input coord_t value);
        return coord_wide_t'(value);
    endfunction

endpackage

// File: rtl/asteroid_controller_rectangle_offset.sv
// rectangle_offset: registers whether the current scan pixel falls inside an
// OBJECT_SIZE x OBJECT_SIZE sprite rectangle, together with the pixel offset
// from the rectangle's top-left corner. The offsets read 0 whenever the pixel
// is outside the rectangle or the sprite is disabled. Usable by any sprite.
module rectangle_offset
    import asteroid_controller_pkg::*;
#(
    parameter int OBJECT_SIZE = 32
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   enable,
    input  coord_t topLeftX,
    input  coord_t topLeftY,
    input  coord_t pixelX,
    input  coord_t pixelY,
    output coord_t offsetX,
    output coord_t offsetY,
    output logic   insideRectangle
);

    localparam coord_wide_t SIZE_W = coord_wide_t'(OBJECT_SIZE);
    localparam coord_wide_t ZERO_W = coord_wide_t'(0);

    coord_wide_t diffX_s;
    coord_wide_t diffY_s;
    logic        inside_s;

    // Pixel position relative to the rectangle origin; inside means 0 <= diff < size on both axes
    always_comb begin
        diffX_s  = widen(pixelX) - widen(topLeftX);
        diffY_s  = widen(pixelY) - widen(topLeftY);
        inside_s = enable
                   && (diffX_s >= ZERO_W) && (diffX_s < SIZE_W)
                   && (diffY_s >= ZERO_W) && (diffY_s < SIZE_W);
    end

    // Register the inside flag and the offsets together, offsets zeroed outside the rectangle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            insideRectangle <= 1'b0;
            offsetX         <= '0;
            offsetY         <= '0;
        end else begin
            insideRectangle <= inside_s;
            offsetX         <= inside_s ? coord_t'(diffX_s[COORD_W-1:0]) : '0;
            offsetY         <= inside_s ? coord_t'(diffY_s[COORD_W-1:0]) : '0;
        end
    end

endmodule

// File: rtl/asteroid_controller.sv
// asteroid_controller: motion and lifecycle control for one asteroid.
// The asteroid spawns above the top edge, falls SPEED_Y pixels per frame,
// explodes for EXPLOSION_FRAMES frames when hit, and retires silently when
// it falls off the bottom of the screen. Scan-pixel rectangle offsets are
// produced by the rectangle_offset sub-module.
// Optional macro ASTEROID_DRIFT_EN adds a +/-1 px/frame horizontal drift that
// bounces between the left and right screen edges.
module asteroid_controller
    import asteroid_controller_pkg::*;
#(
    parameter int OBJECT_SIZE      = 32,
    parameter int SPEED_Y          = 2,
    parameter int EXPLOSION_FRAMES = 30
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   startOfFrame,
    input  coord_t pixelX,
    input  coord_t pixelY,
    input  logic   spawn,
    input  coord_t spawnX,
    input  logic   collision,
    output coord_t offsetX,
    output coord_t offsetY,
    output logic   InsideRectangle,
    output logic   asteroidIsHit,
    output logic   asteroidActive,
    output logic   asteroidDestroyed
);

    localparam int               CNT_W      = (EXPLOSION_FRAMES > 1) ? $clog2(EXPLOSION_FRAMES) : 1;
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(EXPLOSION_FRAMES - 1);
    localparam coord_t           SPAWN_Y    = coord_t'(-OBJECT_SIZE);
    localparam coord_t           SPEED_C    = coord_t'(SPEED_Y);
    localparam coord_t           RETIRE_Y   = coord_t'(SCREEN_HEIGHT);

    asteroid_state_t  state_r;
    coord_t           topLeftX_r;
    coord_t           topLeftY_r;
    logic [CNT_W-1:0] frameCount_r;

    coord_t nextY_s;
    logic   retire_s;

    // Vertical step for the next frame and the bottom-of-screen retirement test
    always_comb begin
        nextY_s  = topLeftY_r + SPEED_C;
        retire_s = (nextY_s >= RETIRE_Y);
    end

`ifdef ASTEROID_DRIFT_EN
    localparam coord_wide_t SIZE_W     = coord_wide_t'(OBJECT_SIZE);
    localparam coord_wide_t WIDTH_W    = coord_wide_t'(SCREEN_WIDTH);
    localparam coord_wide_t ONE_W      = coord_wide_t'(1);
    localparam coord_wide_t ZERO_W     = coord_wide_t'(0);
    localparam coord_t      RIGHT_X    = coord_t'(SCREEN_WIDTH - OBJECT_SIZE);
    localparam coord_t      LEFT_X     = coord_t'(0);

    logic        velNeg_r;
    logic        nextVelNeg_s;
    coord_wide_t stepX_s;
    coord_t      nextX_s;

    // Horizontal step; hitting either edge reverses direction and clamps X on the same frame
    always_comb begin
        if (velNeg_r) begin
            stepX_s = widen(topLeftX_r) - ONE_W;
        end else begin
            stepX_s = widen(topLeftX_r) + ONE_W;
        end
        if ((stepX_s + SIZE_W) >= WIDTH_W) begin
            nextVelNeg_s = 1'b1;
            nextX_s      = RIGHT_X;
        end else if (stepX_s <= ZERO_W) begin
            nextVelNeg_s = 1'b0;
            nextX_s      = LEFT_X;
        end else begin
            nextVelNeg_s = velNeg_r;
            nextX_s      = coord_t'(stepX_s[COORD_W-1:0]);
        end
    end
`endif

    // Lifecycle FSM with position registers and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r           <= ST_IDLE;
            topLeftX_r        <= '0;
            topLeftY_r        <= '0;
            frameCount_r      <= '0;
            asteroidIsHit     <= 1'b0;
            asteroidActive    <= 1'b0;
            asteroidDestroyed <= 1'b0;
`ifdef ASTEROID_DRIFT_EN
            velNeg_r          <= 1'b0;
`endif
        end else begin
            asteroidDestroyed <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (spawn) begin
                        state_r        <= ST_FALLING;
                        topLeftX_r     <= spawnX;
                        topLeftY_r     <= SPAWN_Y;
                        asteroidActive <= 1'b1;
                        asteroidIsHit  <= 1'b0;
`ifdef ASTEROID_DRIFT_EN
                        velNeg_r       <= 1'b0;
`endif
                    end
                end
                ST_FALLING: begin
                    // A hit takes priority over motion, freezing the position
                    if (collision && InsideRectangle) begin
                        state_r       <= ST_EXPLODING;
                        frameCount_r  <= '0;
                        asteroidIsHit <= 1'b1;
                    end else if (startOfFrame) begin
                        topLeftY_r <= nextY_s;
`ifdef ASTEROID_DRIFT_EN
                        topLeftX_r <= nextX_s;
                        velNeg_r   <= nextVelNeg_s;
`endif
                        if (retire_s) begin
                            state_r        <= ST_IDLE;
                            asteroidActive <= 1'b0;
                        end
                    end
                end
                ST_EXPLODING: begin
                    if (startOfFrame) begin
                        if (frameCount_r == LAST_FRAME) begin
                            state_r           <= ST_IDLE;
                            asteroidIsHit     <= 1'b0;
                            asteroidActive    <= 1'b0;
                            asteroidDestroyed <= 1'b1;
                        end else begin
                            frameCount_r <= frameCount_r + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    asteroidIsHit  <= 1'b0;
                    asteroidActive <= 1'b0;
                end
            endcase
        end
    end

    rectangle_offset #(
        .OBJECT_SIZE (OBJECT_SIZE)
    ) rectOffset (
        .clk             (clk),
        .reset           (reset),
        .enable          (asteroidActive),
        .topLeftX        (topLeftX_r),
        .topLeftY        (topLeftY_r),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .insideRectangle (InsideRectangle)
    );

endmodule

// File: tb/tb_asteroid_controller.sv
// Directed testbench for asteroid_controller: spawn, falling, rectangle
// offsets, hit/explosion, retirement, async reset and the drift feature
// (ASTEROID_DRIFT_EN selects which drift expectations apply).
module tb_asteroid_controller;
    import asteroid_controller_pkg::*;

    logic   clk = 1'b0;
    logic   reset;
    logic   startOfFrame;
    coord_t pixelX;
    coord_t pixelY;
    logic   spawn;
    coord_t spawnX;
    logic   collision;
    coord_t offsetX;
    coord_t offsetY;
    logic   InsideRectangle;
    logic   asteroidIsHit;
    logic   asteroidActive;
    logic   asteroidDestroyed;

    int vecCount        = 0;
    int failCount       = 0;
    int destroyedCycles = 0;

`ifdef ASTEROID_DRIFT_EN
    int driftExp [4] = '{13, 12, 13, 14};
`else
    int driftExp [4] = '{14, 14, 14, 14};
`endif

    always #5 clk = ~clk;

    asteroid_controller dut (
        .clk               (clk),
        .reset             (reset),
        .startOfFrame      (startOfFrame),
        .pixelX            (pixelX),
        .pixelY            (pixelY),
        .spawn             (spawn),
        .spawnX            (spawnX),
        .collision         (collision),
        .offsetX           (offsetX),
        .offsetY           (offsetY),
        .InsideRectangle   (InsideRectangle),
        .asteroidIsHit     (asteroidIsHit),
        .asteroidActive    (asteroidActive),
        .asteroidDestroyed (asteroidDestroyed)
    );

    // Count every cycle in which the destroyed pulse is high
    always @(negedge clk) begin
        if (asteroidDestroyed === 1'b1) destroyedCycles++;
    end

    task automatic checkVector(input string tag, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            failCount++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
        end
    endtask

    task automatic doSpawn(input int x);
        spawnX = coord_t'(x);
        spawn  = 1'b1;
        tick();
        spawn  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; startOfFrame = 1'b0; spawn = 1'b0; collision = 1'b0;
        pixelX = '0; pixelY = '0; spawnX = '0;
        tick(); tick();
        checkVector("rst_active",    asteroidActive,    0);
        checkVector("rst_hit",       asteroidIsHit,     0);
        checkVector("rst_destroyed", asteroidDestroyed, 0);
        checkVector("rst_inside",    InsideRectangle,   0);
        checkVector("rst_offx",      offsetX,           0);
        checkVector("rst_offy",      offsetY,           0);
        reset = 1'b0;
        tick();

        // Spawn at x=100, Y starts at -32
        doSpawn(100);
        checkVector("spawn_active", asteroidActive, 1);
        checkVector("spawn_hit",    asteroidIsHit,  0);
        frames(10);                                   // Y = -12, partly above row 0
        pixelX = 11'sd100; pixelY = 11'sd0; tick();
        checkVector("above_inside", InsideRectangle, 1);
        checkVector("above_offx",   offsetX,         0);
        checkVector("above_offy",   offsetY,         12);
        frames(10);                                   // Y = 8
        pixelX = 11'sd110; pixelY = 11'sd20; tick();
        checkVector("pix110_inside", InsideRectangle, 1);
        checkVector("pix110_offx",   offsetX,         10);
        checkVector("pix110_offy",   offsetY,         12);
        pixelX = 11'sd132; tick();
        checkVector("pix132_inside", InsideRectangle, 0);
        checkVector("pix132_offx",   offsetX,         0);
        checkVector("pix132_offy",   offsetY,         0);
        pixelX = 11'sd131; pixelY = 11'sd39; tick();
        checkVector("corner_inside", InsideRectangle, 1);
        checkVector("corner_offx",   offsetX,         31);
        checkVector("corner_offy",   offsetY,         31);
        pixelX = 11'sd100; pixelY = 11'sd40; tick();
        checkVector("below_inside", InsideRectangle, 0);
        pixelX = 11'sd99; pixelY = 11'sd8; tick();
        checkVector("left_inside", InsideRectangle, 0);

        // Hit while the scan pixel is inside the rectangle
        pixelX = 11'sd110; pixelY = 11'sd20; tick();
        checkVector("prehit_inside", InsideRectangle, 1);
        collision = 1'b1; tick(); collision = 1'b0;
        checkVector("hit_flag",   asteroidIsHit,  1);
        checkVector("hit_active", asteroidActive, 1);
        doSpawn(300);                                 // must be ignored
        tick();
        checkVector("xspawn_hit",  asteroidIsHit, 1);
        checkVector("xspawn_offx", offsetX,       10);
        checkVector("xspawn_offy", offsetY,       12);
        frames(5);
        checkVector("frozen_offy", offsetY, 12);
        frames(24);                                   // 29 frames so far
        checkVector("boom29_active",    asteroidActive, 1);
        checkVector("boom29_destroyed", destroyedCycles, 0);
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        checkVector("boom30_destroyed", asteroidDestroyed, 1);
        checkVector("boom30_active",    asteroidActive,    0);
        checkVector("boom30_hit",       asteroidIsHit,     0);
        tick();
        checkVector("post_destroyed", asteroidDestroyed, 0);
        checkVector("post_inside",    InsideRectangle,   0);
        checkVector("destroy_count",  destroyedCycles,   1);

        // Asynchronous reset in the middle of FALLING
        doSpawn(100);
        frames(5);                                    // Y = -22
        pixelX = 11'sd110; pixelY = 11'sd0; tick();
        checkVector("mid_inside", InsideRectangle, 1);
        checkVector("mid_offy",   offsetY,         22);
        #2 reset = 1'b1;
        #1;
        checkVector("arst_active", asteroidActive,  0);
        checkVector("arst_inside", InsideRectangle, 0);
        checkVector("arst_offy",   offsetY,         0);
        reset = 1'b0;
        tick();
        checkVector("arst_idle",      asteroidActive,  0);
        checkVector("arst_destroyed", destroyedCycles, 1);

        // Unhit asteroid retires after 256 frames without a destroyed pulse
        doSpawn(200);
        frames(255);                                  // Y = 478
        checkVector("retire_pre_active", asteroidActive, 1);
        frames(1);                                    // Y = 480
        checkVector("retire_active",    asteroidActive,  0);
        checkVector("retire_destroyed", destroyedCycles, 1);

        // Collision coinciding with startOfFrame: hit wins, Y stays at 8
        doSpawn(50);
        frames(20);
        pixelX = 11'sd60; pixelY = 11'sd20; tick();
        checkVector("coin_pre_offy", offsetY, 12);
        collision = 1'b1; startOfFrame = 1'b1; tick();
        collision = 1'b0; startOfFrame = 1'b0;
        checkVector("coin_hit", asteroidIsHit, 1);
        tick();
        checkVector("coin_offy", offsetY, 12);
        checkVector("coin_offx", offsetX, 10);

        // Horizontal drift near the right edge (constant X when drift is absent)
        reset = 1'b1; tick(); reset = 1'b0; tick();
        doSpawn(606);
        pixelX = 11'sd620; pixelY = 11'sd0;
        for (int i = 0; i < 4; i++) begin
            frames(1);
            checkVector($sformatf("drift%0d_offx", i), offsetX, driftExp[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
